// File: rtl/blake2b_pkg.sv
// Shared constants and FSM state type for the BLAKE2b message controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package blake2b_pkg;

    localparam int WORD_BYTES  = 8;
    localparam int BLOCK_BYTES = 128;
    localparam int WORD_W      = 8 * WORD_BYTES;
    localparam int WORDS       = BLOCK_BYTES / WORD_BYTES;
    localparam int IDX_W       = $clog2(WORDS);
    localparam int DIGEST_W    = 512;
    localparam int BLOCK_W     = 1024;
    localparam int CTR_W       = 128;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_CMD_WAIT,
        ST_FILL,
        ST_HOLD,
        ST_NEXT,
        ST_FINAL,
        ST_DIG_WAIT,
        ST_DIG_OUT
    } state_t;

    // Keeps the first nb bytes of a beat (first byte in the MSBs); nb > 8 keeps all.
    function automatic logic [WORD_W-1:0] byte_mask(input logic [3:0] nb);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            m[WORD_W-1-8*b -: 8] = (b < int'(nb)) ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/blake2b_blk_pack.sv
// Block packer: 16-word buffer, word index, masked last-beat write, running byte counter.
// Latency: a write is visible in the buffer the next cycle; load copies buffer/counter to block/length in one cycle.
// Backpressure: none here; the controller only asserts wr_en while it is accepting beats.
//
// Ports: wr_en/wr_data/wr_last/wr_nbytes write one beat at word idx; load captures the
// buffer and counter onto blk/len (held until the next load); clr_blk empties the buffer
// and index; clr_all additionally clears the byte counter.
module blake2b_blk_pack
    import blake2b_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr_all,
    input  logic                 clr_blk,
    input  logic                 wr_en,
    input  logic [WORD_W-1:0]    wr_data,
    input  logic                 wr_last,
    input  logic [3:0]           wr_nbytes,
    input  logic                 load,
    output logic [IDX_W-1:0]     idx,
    output logic [BLOCK_W-1:0]   blk,
    output logic [CTR_W-1:0]     len
);

    // Element WORDS-1 sits in the top bits, so word 0 of the message maps there.
    logic [WORDS-1:0][WORD_W-1:0] buf_q;
    logic [IDX_W-1:0]             idx_q;
    logic [CTR_W-1:0]             ctr_q;
    logic [BLOCK_W-1:0]           blk_q;
    logic [CTR_W-1:0]             len_q;
    logic [3:0]                   nb;
    logic [WORD_W-1:0]            wr_masked;

    // Non-last beats always carry a full word; a last beat carries min(wr_nbytes, 8).
    always_comb begin
        nb = 4'd8;
        if (wr_last && (wr_nbytes < 4'd8)) begin
            nb = wr_nbytes;
        end
        wr_masked = wr_data & byte_mask(nb);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_q <= '0;
            idx_q <= '0;
            ctr_q <= '0;
            blk_q <= '0;
            len_q <= '0;
        end else begin
            if (load) begin
                blk_q <= buf_q;
                len_q <= ctr_q;
            end
            if (clr_all) begin
                buf_q <= '0;
                idx_q <= '0;
                ctr_q <= '0;
            end else if (clr_blk) begin
                buf_q <= '0;
                idx_q <= '0;
            end else if (wr_en) begin
                buf_q[IDX_W'(WORDS-1) - idx_q] <= wr_masked;
                idx_q <= idx_q + 1'b1;
                ctr_q <= ctr_q + CTR_W'(nb);
            end
        end
    end

    assign idx = idx_q;
    assign blk = blk_q;
    assign len = len_q;

endmodule

// File: rtl/blake2b_msg_ctrl.sv
// BLAKE2b-512 initiator: packs 64-bit beats into blocks, issues init/next/final, returns the digest.
// Latency: commands are registered (one cycle after the deciding state); digest appears one cycle after digest_valid.
// Backpressure: in_ready only in FILL; a full block is held until another beat is offered; dig_valid holds until dig_ready.
//
// Ports: in_valid/in_ready/in_data/in_last/in_nbytes message stream (first byte in [63:56]);
// init_512/next_512/final_512 one-cycle core commands with block/length_512 (plain 'final'
// is a reserved word, hence final_512); ready_512/digest_512/digest_valid from the core;
// dig_valid/dig_ready/dig_data digest output. Build option BLAKE2_CTRL_PERF_EN adds
// perf_cycles, the saturating cycle count from the init pulse to the digest capture.
module blake2b_msg_ctrl
    import blake2b_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    in_data,
    input  logic                 in_last,
    input  logic [3:0]           in_nbytes,
    output logic                 init_512,
    output logic                 next_512,
    output logic                 final_512,
    output logic [BLOCK_W-1:0]   block,
    output logic [CTR_W-1:0]     length_512,
    input  logic                 ready_512,
    input  logic [DIGEST_W-1:0]  digest_512,
    input  logic                 digest_valid,
    output logic                 dig_valid,
    input  logic                 dig_ready,
    output logic [DIGEST_W-1:0]  dig_data
`ifdef BLAKE2_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_cycles
`endif
);

    state_t              state_q, state_d;
    logic [1:0]          win_q;
    logic                init_q, next_q, final_q;
    logic                init_d, next_d, final_d;
    logic                wr_en, load, clr_blk, clr_all, capture;
    logic [IDX_W-1:0]    idx;
    logic [DIGEST_W-1:0] dig_q;

    // The core only reacts to a command after seeing it, so ready_512 and a stale
    // digest_valid are not trusted for the issue cycle and the one after (win_q != 0).
    always_comb begin
        state_d = state_q;
        init_d  = 1'b0;
        next_d  = 1'b0;
        final_d = 1'b0;
        wr_en   = 1'b0;
        load    = 1'b0;
        clr_blk = 1'b0;
        clr_all = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_INIT;
            end
            ST_INIT: begin
                if (ready_512) begin
                    init_d  = 1'b1;
                    state_d = ST_CMD_WAIT;
                end
            end
            ST_CMD_WAIT: begin
                if ((win_q == 2'd0) && ready_512) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (in_last) begin
                        state_d = ST_FINAL;
                    end else if (idx == IDX_W'(WORDS-1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // A full block might be the last one; only more data proves it is not.
                if (in_valid) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (ready_512) begin
                    next_d  = 1'b1;
                    load    = 1'b1;
                    clr_blk = 1'b1;
                    state_d = ST_CMD_WAIT;
                end
            end
            ST_FINAL: begin
                if (ready_512) begin
                    final_d = 1'b1;
                    load    = 1'b1;
                    state_d = ST_DIG_WAIT;
                end
            end
            ST_DIG_WAIT: begin
                if ((win_q == 2'd0) && digest_valid) begin
                    capture = 1'b1;
                    state_d = ST_DIG_OUT;
                end
            end
            ST_DIG_OUT: begin
                if (dig_ready) begin
                    clr_all = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            win_q   <= 2'd0;
            init_q  <= 1'b0;
            next_q  <= 1'b0;
            final_q <= 1'b0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            next_q  <= next_d;
            final_q <= final_d;
            if (init_d || next_d || final_d) begin
                win_q <= 2'd2;
            end else if (win_q != 2'd0) begin
                win_q <= win_q - 1'b1;
            end
            if (capture) dig_q <= digest_512;
        end
    end

    blake2b_blk_pack u_pack (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_all   (clr_all),
        .clr_blk   (clr_blk),
        .wr_en     (wr_en),
        .wr_data   (in_data),
        .wr_last   (in_last),
        .wr_nbytes (in_nbytes),
        .load      (load),
        .idx       (idx),
        .blk       (block),
        .len       (length_512)
    );

    assign in_ready  = (state_q == ST_FILL);
    assign dig_valid = (state_q == ST_DIG_OUT);
    assign dig_data  = dig_q;
    assign init_512  = init_q;
    assign next_512  = next_q;
    assign final_512 = final_q;

`ifdef BLAKE2_CTRL_PERF_EN
    logic        perf_run_q;
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_run_q <= 1'b0;
            perf_q     <= '0;
        end else if (init_q) begin
            perf_run_q <= 1'b1;
            perf_q     <= '0;
        end else if (perf_run_q) begin
            if (capture) perf_run_q <= 1'b0;
            if (perf_q != 32'hFFFF_FFFF) perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_blake2b_msg_ctrl.sv
// Self-checking bench for blake2b_msg_ctrl with a behavioural core model and a command scoreboard.
// Latency: n/a.
// Backpressure: randomized beat gaps, core stalls and digest-consumer stalls.
module tb_blake2b_msg_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          in_valid, in_ready, in_last;
    logic [63:0]   in_data;
    logic [3:0]    in_nbytes;
    logic          init_512, next_512, final_512;
    logic [1023:0] block;
    logic [127:0]  length_512;
    logic          ready_512, digest_valid;
    logic [511:0]  digest_512;
    logic          dig_valid, dig_ready;
    logic [511:0]  dig_data;

    blake2b_msg_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_nbytes    (in_nbytes),
        .init_512     (init_512),
        .next_512     (next_512),
        .final_512    (final_512),
        .block        (block),
        .length_512   (length_512),
        .ready_512    (ready_512),
        .digest_512   (digest_512),
        .digest_valid (digest_valid),
        .dig_valid    (dig_valid),
        .dig_ready    (dig_ready),
        .dig_data     (dig_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // ---------------- core model: busy for stall_cyc after any command ----------------
    int           stall_cyc = 2;
    int           busy = 0;
    logic         pend_fin = 1'b0;
    logic         dv = 1'b0;
    logic [511:0] msg_digest = '0;
    logic [511:0] dig_reg = '0;

    assign ready_512    = (busy == 0);
    assign digest_valid = dv;
    assign digest_512   = dig_reg;

    always @(posedge clk) begin
        if (!reset_n) begin
            busy     <= 0;
            dv       <= 1'b0;
            pend_fin <= 1'b0;
            dig_reg  <= '0;
        end else if (init_512 || next_512 || final_512) begin
            busy     <= stall_cyc;
            dv       <= 1'b0;
            pend_fin <= final_512;
            dig_reg  <= ~msg_digest;
        end else if (busy > 0) begin
            busy <= busy - 1;
            if (busy == 1 && pend_fin) begin
                dv       <= 1'b1;
                dig_reg  <= msg_digest;
                pend_fin <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard and compare process ----------------
    typedef struct {
        int             kind;   // 0 init, 1 next, 2 final
        logic [1023:0]  blk;
        logic [127:0]   len;
    } cmd_t;

    cmd_t         exp_q[$];
    cmd_t         mon_e;
    logic [511:0] exp_dig = '0;
    int           n_init = 0, n_next = 0, n_fin = 0;
    int           mon_n, mon_kind;
    logic         prev_hold = 1'b0;
    logic [511:0] prev_dig = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            mon_n = int'(init_512) + int'(next_512) + int'(final_512);
            if (mon_n != 0) begin
                chk("cmd_onehot", 512'(mon_n), 512'd1);
                if (init_512)  n_init++;
                if (next_512)  n_next++;
                if (final_512) n_fin++;
                mon_kind = init_512 ? 0 : (next_512 ? 1 : 2);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cmd_unexpected got kind=%0d want no command", mon_kind);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("cmd_kind", 512'(mon_kind), 512'(mon_e.kind));
                    if (mon_e.kind != 0) begin
                        chk("cmd_blk_hi", block[1023:512], mon_e.blk[1023:512]);
                        chk("cmd_blk_lo", block[511:0], mon_e.blk[511:0]);
                        chk("cmd_len", 512'(length_512), 512'(mon_e.len));
                    end
                end
            end
            if (prev_hold) begin
                chk("dig_valid_held", 512'(dig_valid), 512'd1);
                chk("dig_data_held", dig_data, prev_dig);
            end
            if (dig_valid) chk("dig_data", dig_data, exp_dig);
            prev_hold = dig_valid && !dig_ready;
            prev_dig  = dig_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [63:0] msg_data [0:63];

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) msg_data[i] = {$urandom, $urandom};
    endtask

    // Offers one beat and waits for acceptance; called at posedge+1.
    task automatic drive_beat(input logic [63:0] d, input logic last, input logic [3:0] nb);
        bit acc;
        int budget;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        in_nbytes = nb;
        acc       = 0;
        budget    = 300;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL beat_timeout got in_ready=0 want 1");
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = {$urandom, $urandom};
    endtask

    task automatic send_msg(input int nbeats, input int last_nb, input int gap_max,
                            input int stall, input int drdy_hold, input logic [511:0] dg);
        cmd_t e;
        int   nblk, eff, base_init, base_next, base_fin, budget;
        bit   seen;
        stall_cyc  = stall;
        msg_digest = dg;
        exp_dig    = dg;
        // Reference: beat j lands in block j/16 at word j%16; all but the last block go with next.
        e.kind = 0; e.blk = '0; e.len = '0;
        exp_q.push_back(e);
        nblk = (nbeats + 15) / 16;
        for (int k = 0; k < nblk; k++) begin
            e.kind = (k == nblk - 1) ? 2 : 1;
            e.blk  = '0;
            e.len  = '0;
            for (int j = 0; j < (k + 1) * 16 && j < nbeats; j++) begin
                eff   = (j == nbeats - 1) ? ((last_nb > 8) ? 8 : last_nb) : 8;
                e.len = e.len + 128'(eff);
                if (j >= k * 16) begin
                    for (int b = 0; b < eff; b++)
                        e.blk[1023 - 8 * ((j % 16) * 8 + b) -: 8] = msg_data[j][63 - 8 * b -: 8];
                end
            end
            exp_q.push_back(e);
        end
        base_init = n_init;
        base_next = n_next;
        base_fin  = n_fin;
        for (int j = 0; j < nbeats; j++) begin
            if (j > 0 && j % 16 == 0) begin
                repeat (4) @(posedge clk);
                #1;
                chk("hold_no_early_next", 512'(n_next - base_next), 512'(j / 16 - 1));
            end
            repeat ($urandom_range(gap_max, 0)) begin
                @(posedge clk);
                #1;
            end
            if (j == nbeats - 1)
                drive_beat(msg_data[j], 1'b1, 4'(last_nb));
            else
                drive_beat(msg_data[j], 1'b0, 4'($urandom_range(15, 0)));
        end
        budget = 600;
        seen   = 0;
        while (!seen && budget > 0) begin
            @(negedge clk);
            seen = dig_valid;
            budget--;
        end
        chk("dig_valid_seen", 512'(seen), 512'd1);
        repeat (drdy_hold) @(negedge clk);
        @(posedge clk);
        #1;
        dig_ready = 1'b1;
        @(posedge clk);
        #1;
        dig_ready = 1'b0;
        @(negedge clk);
        chk("dig_valid_drop", 512'(dig_valid), 512'd0);
        chk("queue_drained", 512'(exp_q.size()), 512'd0);
        chk("init_count", 512'(n_init - base_init), 512'd1);
        chk("next_count", 512'(n_next - base_next), 512'(nblk - 1));
        chk("final_count", 512'(n_fin - base_fin), 512'd1);
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, "_cmds"}, 512'({init_512, next_512, final_512}), 512'd0);
        chk({tag, "_blk_hi"}, block[1023:512], 512'd0);
        chk({tag, "_blk_lo"}, block[511:0], 512'd0);
        chk({tag, "_len"}, 512'(length_512), 512'd0);
        chk({tag, "_flags"}, 512'({in_ready, dig_valid}), 512'd0);
        chk({tag, "_dig"}, dig_data, 512'd0);
    endtask

    // ---------------- test sequence ----------------
    logic [63:0]   fl;
    logic [511:0]  a5;
    logic [1023:0] tmp;
    cmd_t          ie;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_nbytes = '0;
        dig_ready = 1'b0;
        fl        = "flamingo";
        a5        = {64{8'hA5}};
        repeat (3) @(posedge clk);
        #1;
        chk_idle("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // one full beat "flamingo"
        msg_data[0] = fl;
        send_msg(1, 8, 2, 3, 2, a5);
        chk("fl_word0", 512'(block[1023:960]), 512'(fl));
        chk("fl_rest_hi", block[959:448], 512'd0);
        chk("fl_rest_lo", 512'(block[447:0]), 512'd0);
        chk("fl_len", 512'(length_512), 512'd8);
        chk("fl_digest", dig_data, a5);

        // zero-length message
        msg_data[0] = {$urandom, $urandom};
        send_msg(1, 0, 1, 2, 0, rand512());
        chk("zero_blk_hi", block[1023:512], 512'd0);
        chk("zero_blk_lo", block[511:0], 512'd0);
        chk("zero_len", 512'(length_512), 512'd0);

        // exactly one block
        fill_random(16);
        send_msg(16, 8, 1, 2, 1, rand512());
        chk("b128_len", 512'(length_512), 512'd128);

        // 129 bytes, slow core after next, slow consumer
        fill_random(17);
        send_msg(17, 1, 1, 20, 10, rand512());
        chk("b129_len", 512'(length_512), 512'd129);
        chk("b129_byte0", 512'(block[1023:1016]), 512'(msg_data[16][63:56]));
        tmp = block;
        tmp[1023:1016] = 8'h00;
        chk("b129_rest_hi", tmp[1023:512], 512'd0);
        chk("b129_rest_lo", tmp[511:0], 512'd0);

        // reset in the middle of FILL
        fill_random(3);
        stall_cyc = 2;
        ie.kind = 0; ie.blk = '0; ie.len = '0;
        exp_q.push_back(ie);
        for (int j = 0; j < 3; j++) drive_beat(msg_data[j], 1'b0, 4'd8);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_idle("midrst");
        @(posedge clk);
        #1;
        fill_random(1);
        send_msg(1, 8, 0, 2, 0, rand512());
        chk("post_rst_len", 512'(length_512), 512'd8);

        // randomized messages
        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(40, 1);
            fill_random(n);
            send_msg(n, $urandom_range(10, 0), $urandom_range(3, 0),
                     $urandom_range(4, 1), $urandom_range(3, 0), rand512());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got no end want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/blake2b_msg_ctrl.md
Name: blake2b_msg_ctrl

Overview:
Initiator side of the BLAKE2b-512 core command interface (init_512/next_512/final/block/length_512, ready_512/digest_512/digest_valid). Accepts a 64-bit message word stream and packs it into 1024-bit blocks. Drives the core's init/next/final commands with the running byte count, captures the 512-bit digest, and presents it on a valid/ready output. Sits between the host data path and the blake2b core.

Parameters:
WORD_BYTES, 8, bytes per input beat (fixed by 64-bit in_data)
BLOCK_BYTES, 128, bytes per BLAKE2b block
CTR_W, 128, width of byte counter / length_512

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
in_valid  in  1  message beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
in_data  in  64  message bytes, first byte in [63:56]
in_last  in  1  last beat of message
in_nbytes  in  4  valid bytes on last beat (0..8); ignored (treated as 8) when in_last=0
init_512  out  1  one-cycle init command to core
next_512  out  1  one-cycle compress-non-final command
final  out  1  one-cycle compress-final command
block  out  1024  block to core; byte i at [1023-8i -: 8]
length_512  out  128  total message bytes up to and including this block
ready_512  in  1  core idle/ready
digest_512  in  512  core digest
digest_valid  in  1  core digest valid
dig_valid  out  1  digest available
dig_ready  in  1  consumer accepts digest
dig_data  out  512  captured digest

Behaviour:
- Reset (reset_n=0 on clk edge): state IDLE; all outputs 0; block buffer, word index, byte counter cleared. Reset mid-operation aborts silently; no command is issued afterwards.
- States: IDLE, INIT, CMD_WAIT, FILL, HOLD, NEXT, FINAL, DIG_WAIT, DIG_OUT.
- IDLE: in_ready=0. in_valid=1 -> INIT.
- INIT: when ready_512=1, pulse init_512 for exactly one cycle -> CMD_WAIT (return to FILL).
- CMD_WAIT: ignore ready_512 for the issue cycle +1, then wait for ready_512=1 -> return state.
- FILL: in_ready=1. Each accepted beat writes word idx (0..15) into the buffer and adds bytes (8, or in_nbytes if last) to the counter. Bytes beyond in_nbytes are written as zero; all unwritten words stay zero.
  - last beat -> FINAL.
  - 16th non-last beat -> HOLD.
- HOLD: buffer full, in_ready=0. A full block is never sent with next until more data is known to exist.
  - in_valid=1 -> NEXT.
- NEXT: when ready_512=1, pulse next_512 with block=buffer and length_512=counter -> CMD_WAIT. On return, buffer and idx are cleared, then FILL.
- FINAL: when ready_512=1, pulse final with block and length_512=counter -> DIG_WAIT.
- Zero-length message: a first beat with in_last=1, in_nbytes=0 gives final with all-zero block and length 0.
- block/length_512 are held stable from the command cycle until the next command; they are 0 after reset.
- DIG_WAIT: on digest_valid=1, capture digest_512 into dig_data -> DIG_OUT.
- DIG_OUT: dig_valid=1 until dig_valid & dig_ready, then IDLE with counter and buffer cleared. dig_data is held until the next capture.
- Counter wraps modulo 2^128; no overflow flag.
- in_nbytes>8 on a last beat is treated as 8.
- At most one of init_512/next_512/final is high in any cycle.

Optional Feature:
BLAKE2_CTRL_PERF_EN:
- Defined: adds output perf_cycles[31:0]. It is cleared at the init_512 pulse and increments every cycle until the digest_valid capture, then holds. Reset value 0; saturates at 0xFFFFFFFF.
- Undefined: port and counter are absent.

Decomposition:
- Package blake2b_pkg: BLOCK_BYTES, WORD_BYTES, DIGEST_W=512, BLOCK_W=1024, CTR_W, state enum type.
- One sub-module, blake2b_blk_pack: buffer, word index, byte masking and counter. The FSM stays in the top.

Test Plan:
- "flamingo" as one beat, nbytes=8, last -> init, then final with block[1023:960]="flamingo", rest 0, length 8; no next. Core model digest 0xA5..A5 appears on dig_data.
- Zero-length: last, nbytes=0 -> final, block=0, length=0.
- Exactly 128 bytes (16 beats, last on 16th) -> single final, length 128; next_512 never asserted.
- 129 bytes -> next with length 128 (held in HOLD until beat 17 valid), then final with length 129, byte 0x?? at [1023:1016], rest zero.
- Core ready_512 held low 20 cycles after next; dig_ready low 10 cycles -> no duplicate commands; dig_valid and dig_data stable until handshake.
- reset_n=0 for one cycle during FILL -> all outputs 0, IDLE; subsequent 8-byte message yields length 8 (counter not stale).
